// File: rtl/bin_img_loader.sv
// Input-side image buffer: packs a byte stream into an IMG_SIZE x IMG_SIZE bitmap and holds it until consumed.
// Optional pad-bit check on the final byte is enabled by defining LOADER_PAD_CHECK_EN.
module bin_img_loader #(
    parameter int IMG_SIZE = 30
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_valid,
    output logic                               rx_ready,
    output logic [IMG_SIZE*IMG_SIZE-1:0]       img_out,
    output logic                               img_valid,
    input  logic                               img_consume,
    output logic [$clog2(((IMG_SIZE*IMG_SIZE)+7)/8+1)-1:0] byte_cnt,
    output logic                               pad_err
);

    localparam int NBITS     = IMG_SIZE * IMG_SIZE;
    localparam int NBYTES    = (NBITS + 7) / 8;
    localparam int CW        = $clog2(NBYTES + 1);
    localparam int LAST_BITS = NBITS - 8 * (NBYTES - 1);

    // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
    // rx_ready depends only on the state and clear, never on rx_valid.
    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [NBITS-1:0]  img_q;
    logic              accept;
    logic              last_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        rx_ready    = 1'b0;
        img_valid   = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        case (state)
            LOAD: begin
                rx_ready    = !clear;
                accept      = rx_valid && !clear;
                last_accept = accept && (cnt_q == CW'(NBYTES - 1));
                if (last_accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                img_valid = 1'b1;
                if (img_consume) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        if (clear) begin
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (state == FULL && img_consume) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Old pixels survive a consume and are overwritten byte by byte on reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q <= '0;
        end else if (clear) begin
            img_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < NBYTES - 1; k++) begin
                if (cnt_q == CW'(k)) begin
                    img_q[k*8 +: 8] <= rx_data;
                end
            end
            if (last_accept) begin
                img_q[NBITS-1 -: LAST_BITS] <= rx_data[LAST_BITS-1:0];
            end
        end
    end

`ifdef LOADER_PAD_CHECK_EN
    localparam logic [7:0] PAD_MASK = 8'(8'hFF << LAST_BITS);
    logic pad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_q <= 1'b0;
        end else if (clear) begin
            pad_q <= 1'b0;
        end else if (last_accept && |(rx_data & PAD_MASK)) begin
            pad_q <= 1'b1;
        end
    end

    assign pad_err = pad_q;
`else
    assign pad_err = 1'b0;
`endif

    assign img_out  = img_q;
    assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_bin_img_loader.sv
// Self-checking bench for bin_img_loader: scoreboarded image loads, backpressure, clear, async reset, pad check.
module tb_bin_img_loader;

    localparam int IMG_SIZE = 30;
    localparam int NBITS    = IMG_SIZE * IMG_SIZE;
    localparam int NBYTES   = (NBITS + 7) / 8;
    localparam int CW       = $clog2(NBYTES + 1);

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [NBITS-1:0]  img_out;
    logic              img_valid;
    logic              img_consume;
    logic [CW-1:0]     byte_cnt;
    logic              pad_err;

    logic [NBITS-1:0]  exp_q[$];
    logic [7:0]        tx_bytes[NBYTES];
    logic [NBITS-1:0]  held;
    int                checks;
    int                failures;

    bin_img_loader #(.IMG_SIZE(IMG_SIZE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .img_out     (img_out),
        .img_valid   (img_valid),
        .img_consume (img_consume),
        .byte_cnt    (byte_cnt),
        .pad_err     (pad_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0; clear = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; img_consume = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // driver: present one byte after `gap` idle cycles; returns 1ns after the accepting edge
    task automatic drive_byte(input logic [7:0] d, input int gap);
        bit ok;
        rx_valid = 1'b0;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = d;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drive_rx_ready: rx_ready=%b required 1 within 200 cycles", rx_ready);
        end
        checks++;
        if (img_valid !== 1'b0) begin
            failures++;
            $display("FAIL pre_accept_img_valid: img_valid=%b required 0", img_valid);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // stream tx_bytes[first..NBYTES-1] and push the expected bitmap
    task automatic load_image(input int first, input int gap_max, input logic [NBITS-1:0] base);
        logic [NBITS-1:0] e;
        e = base;
        for (int k = first; k < NBYTES; k++) begin
            for (int i = 0; i < 8; i++)
                if (k * 8 + i < NBITS) e[k*8+i] = tx_bytes[k][i];
            drive_byte(tx_bytes[k], (gap_max == 0) ? 0 : int'($urandom_range(1, gap_max)));
            checks++;
            if (byte_cnt !== CW'(k + 1)) begin
                failures++;
                $display("FAIL byte_cnt_advance: byte_cnt=%0d required %0d", byte_cnt, k + 1);
            end
        end
        exp_q.push_back(e);
        checks++;
        if (img_valid !== 1'b1) begin
            failures++;
            $display("FAIL img_valid_after_last: img_valid=%b required 1", img_valid);
        end
    endtask

    // scoreboard: pop expected bitmap when the DUT presents one
    task automatic check_image(input string name);
        logic [NBITS-1:0] e;
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (img_valid === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_present: img_valid=%b queued=%0d required valid with one queued", name, img_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (img_out !== e) begin
                failures++;
                $display("FAIL %s_img: img_out low=%h required low=%h", name, img_out[63:0], e[63:0]);
            end
            checks++;
            if (byte_cnt !== CW'(NBYTES)) begin
                failures++;
                $display("FAIL %s_cnt: byte_cnt=%0d required %0d", name, byte_cnt, NBYTES);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic consume();
        img_consume = 1'b1;
        @(posedge clk); #1;
        img_consume = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (img_out !== '0 || img_valid !== 1'b0 || byte_cnt !== '0 || pad_err !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: img_valid=%b byte_cnt=%0d pad_err=%b rx_ready=%b img_or=%b required 0 0 0 1 0",
                     img_valid, byte_cnt, pad_err, rx_ready, |img_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NBYTES; k++) tx_bytes[k] = 8'(k);
        load_image(0, 0, '0);
        checks++;
        if (img_out[7:0] !== 8'h00 || img_out[15:8] !== 8'h01 || img_out[899:896] !== 4'h0) begin
            failures++;
            $display("FAIL b2b_slices: [7:0]=%h [15:8]=%h [899:896]=%h required 00 01 0",
                     img_out[7:0], img_out[15:8], img_out[899:896]);
        end
        check_image("b2b");
    endtask

    task automatic test_backpressure();
        held = img_out;
        rx_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rx_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if (rx_ready !== 1'b0 || img_out !== held || img_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold: rx_ready=%b img_valid=%b changed=%b required 0 1 0",
                         rx_ready, img_valid, img_out !== held);
            end
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        consume();
        checks++;
        if (img_valid !== 1'b0 || rx_ready !== 1'b1 || byte_cnt !== '0) begin
            failures++;
            $display("FAIL bp_release: img_valid=%b rx_ready=%b byte_cnt=%0d required 0 1 0",
                     img_valid, rx_ready, byte_cnt);
        end
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        checks++;
        if (img_out[7:0] !== 8'hFF || byte_cnt !== CW'(1) || img_out[15:8] !== 8'h01) begin
            failures++;
            $display("FAIL bp_first_byte: [7:0]=%h [15:8]=%h byte_cnt=%0d required ff 01 1",
                     img_out[7:0], img_out[15:8], byte_cnt);
        end
        // finish this image on top of the retained contents
        tx_bytes[0] = 8'hFF;
        for (int k = 1; k < NBYTES; k++) tx_bytes[k] = 8'($urandom);
        held[7:0] = 8'hFF;
        load_image(1, 0, held);
        check_image("bp_reload");
        consume();
    endtask

    task automatic test_gapped();
        for (int k = 0; k < NBYTES; k++) tx_bytes[k] = 8'(k);
        load_image(0, 3, '0);
        check_image("gapped");
        consume();
    endtask

    task automatic test_clear_mid();
        for (int k = 0; k < NBYTES; k++) tx_bytes[k] = 8'($urandom);
        for (int k = 0; k < 50; k++) drive_byte(tx_bytes[k], 0);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        clear    = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_rx_ready: rx_ready=%b required 0", rx_ready);
        end
        @(posedge clk); #1;
        clear = 1'b0; rx_valid = 1'b0;
        checks++;
        if (byte_cnt !== '0 || img_out !== '0) begin
            failures++;
            $display("FAIL clear_state: byte_cnt=%0d img_or=%b required 0 0", byte_cnt, |img_out);
        end
        load_image(0, 0, '0);
        check_image("clear_reload");
        consume();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < NBYTES; k++) tx_bytes[k] = 8'($urandom);
        for (int k = 0; k < 60; k++) drive_byte(tx_bytes[k], 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (img_out !== '0 || img_valid !== 1'b0 || byte_cnt !== '0 || pad_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: img_valid=%b byte_cnt=%0d pad_err=%b img_or=%b required 0 0 0 0",
                     img_valid, byte_cnt, pad_err, |img_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < NBYTES; k++) tx_bytes[k] = 8'($urandom);
        load_image(0, 1, '0);
        check_image("post_reset");
        consume();
    endtask

    task automatic test_pad_check();
        logic exp_pad;
`ifdef LOADER_PAD_CHECK_EN
        exp_pad = 1'b1;
`else
        exp_pad = 1'b0;
`endif
        pulse_clear();
        for (int k = 0; k < NBYTES; k++) tx_bytes[k] = 8'($urandom);
        tx_bytes[NBYTES-1] = 8'hF3;
        load_image(0, 0, '0);
        checks++;
        if (img_out[899:896] !== 4'h3 || pad_err !== exp_pad) begin
            failures++;
            $display("FAIL pad_set: [899:896]=%h pad_err=%b required 3 %b", img_out[899:896], pad_err, exp_pad);
        end
        check_image("pad");
        consume();
        checks++;
        if (pad_err !== exp_pad) begin
            failures++;
            $display("FAIL pad_sticky: pad_err=%b required %b", pad_err, exp_pad);
        end
        pulse_clear();
        checks++;
        if (pad_err !== 1'b0) begin
            failures++;
            $display("FAIL pad_clear: pad_err=%b required 0", pad_err);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_gapped();
        test_clear_mid();
        test_async_reset();
        test_pad_check();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: queued=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
